// File: rtl/maze_player_mover.sv
// rtl/maze_player_mover.sv - grid player mover with edge check, wall lookup, auto-repeat and goal flag
//
// Purpose: takes one-hot key directions, validates each move against the grid
// edges and then against an external wall map (request/valid handshake), and
// keeps the registered player position for the renderer.
//
// Ports:
//   clock, reset            clock; asynchronous active-low reset
//   direction[3:0]          one-hot key code (0001 up, 0010 down, 0100 right, 1000 left)
//   restart                 synchronous pulse: back to start, clear at_goal
//   wall_req/wall_x/wall_y  wall lookup request and target cell (stable while requesting)
//   wall_valid/wall_is_wall lookup answer, sampled together
//   pos_x/pos_y             current player cell
//   moved/blocked           one-cycle result pulses
//   at_goal                 level: player sits on the goal cell
//   busy                    FSM is not idle

module maze_player_mover #(
    parameter int COORD_W        = 4,
    parameter int GRID_W         = 16,
    parameter int GRID_H         = 16,
    parameter int START_X        = 0,
    parameter int START_Y        = 0,
    parameter int GOAL_X         = 15,
    parameter int GOAL_Y         = 15,
    parameter int REPEAT_CYCLES  = 12500000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         direction,
    input  logic               restart,
    output logic               wall_req,
    output logic [COORD_W-1:0] wall_x,
    output logic [COORD_W-1:0] wall_y,
    input  logic               wall_valid,
    input  logic               wall_is_wall,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               moved,
    output logic               blocked,
    output logic               at_goal,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [REP_W-1:0]   REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] X_START  = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y_START  = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] X_GOAL   = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] Y_GOAL   = COORD_W'(GOAL_Y);
    localparam logic               START_IS_GOAL = (START_X == GOAL_X) && (START_Y == GOAL_Y);

    logic [1:0]         state_q,   state_d;
    logic [COORD_W-1:0] pos_x_q,   pos_x_d;
    logic [COORD_W-1:0] pos_y_q,   pos_y_d;
    logic [COORD_W-1:0] tgt_x_q,   tgt_x_d;
    logic [COORD_W-1:0] tgt_y_q,   tgt_y_d;
    logic               hit_q,     hit_d;
    logic [TMO_W-1:0]   tmo_q,     tmo_d;
    logic [REP_W-1:0]   rep_q,     rep_d;
    logic [3:0]         dir_q,     dir_d;
    logic               moved_q,   moved_d;
    logic               blocked_q, blocked_d;
    logic               at_goal_q, at_goal_d;

    logic               dir_onehot;
    logic               dir_held;
    logic               rep_hit;
    logic               fire;
    logic               off_grid;
    logic [COORD_W-1:0] step_x;
    logic [COORD_W-1:0] step_y;

    // Key decode and auto-repeat. The repeat counter measures cycles since the
    // last fire of a held key; it runs regardless of FSM state, so a repeat
    // that lands while a lookup is in flight is simply dropped.
    always_comb begin
        dir_onehot = (direction != 4'b0000) && ((direction & (direction - 4'd1)) == 4'b0000);
        dir_held   = (direction == dir_q);
        rep_hit    = (rep_q == REP_LAST);
        fire       = dir_onehot && (!dir_held || rep_hit);
        dir_d      = direction;
        if (!dir_onehot || !dir_held || rep_hit) begin
            rep_d = '0;
        end else begin
            rep_d = rep_q + REP_W'(1);
        end
    end

    // Neighbour cell and grid-edge test; an edge hit never wraps.
    always_comb begin
        step_x   = pos_x_q;
        step_y   = pos_y_q;
        off_grid = 1'b0;
        case (direction)
            4'b0001: begin
                step_y   = pos_y_q - COORD_W'(1);
                off_grid = (pos_y_q == '0);
            end
            4'b0010: begin
                step_y   = pos_y_q + COORD_W'(1);
                off_grid = (pos_y_q == Y_MAX);
            end
            4'b0100: begin
                step_x   = pos_x_q + COORD_W'(1);
                off_grid = (pos_x_q == X_MAX);
            end
            4'b1000: begin
                step_x   = pos_x_q - COORD_W'(1);
                off_grid = (pos_x_q == '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        tgt_x_d   = tgt_x_q;
        tgt_y_d   = tgt_y_q;
        hit_d     = hit_q;
        tmo_d     = tmo_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        at_goal_d = at_goal_q;

        if (restart) begin
            // Dropping to IDLE deasserts wall_req, so any answer still in
            // flight arrives while REQ is not active and is ignored.
            state_d   = ST_IDLE;
            pos_x_d   = X_START;
            pos_y_d   = Y_START;
            at_goal_d = START_IS_GOAL;
            tmo_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fire && !at_goal_q) begin
                        if (off_grid) begin
                            blocked_d = 1'b1;
                        end else begin
                            tgt_x_d = step_x;
                            tgt_y_d = step_y;
                            tmo_d   = '0;
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (wall_valid) begin
                        hit_d   = wall_is_wall;
                        state_d = ST_COMMIT;
                    end else if (tmo_q == TMO_LAST) begin
                        blocked_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_COMMIT: begin
                    if (hit_q) begin
                        blocked_d = 1'b1;
                    end else begin
                        pos_x_d = tgt_x_q;
                        pos_y_d = tgt_y_q;
                        moved_d = 1'b1;
                        if (tgt_x_q == X_GOAL && tgt_y_q == Y_GOAL) begin
                            at_goal_d = 1'b1;
                        end
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pos_x_q   <= X_START;
            pos_y_q   <= Y_START;
            tgt_x_q   <= '0;
            tgt_y_q   <= '0;
            hit_q     <= 1'b0;
            tmo_q     <= '0;
            rep_q     <= '0;
            dir_q     <= 4'b0000;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            at_goal_q <= START_IS_GOAL;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            tgt_x_q   <= tgt_x_d;
            tgt_y_q   <= tgt_y_d;
            hit_q     <= hit_d;
            tmo_q     <= tmo_d;
            rep_q     <= rep_d;
            dir_q     <= dir_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
            at_goal_q <= at_goal_d;
        end
    end

    assign wall_req = (state_q == ST_REQ);
    assign wall_x   = tgt_x_q;
    assign wall_y   = tgt_y_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign moved    = moved_q;
    assign blocked  = blocked_q;
    assign at_goal  = at_goal_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_maze_player_mover.sv
// tb/tb_maze_player_mover.sv - scoreboard bench for maze_player_mover

module tb_maze_player_mover;

    localparam int REP = 8;
    localparam int TMO = 16;

    localparam int K_LOOK  = 0;
    localparam int K_MOVE  = 1;
    localparam int K_BLOCK = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] direction;
    logic       restart;
    logic       wall_req;
    logic [3:0] wall_x, wall_y;
    logic       wall_valid;
    logic       wall_is_wall;
    logic [3:0] pos_x, pos_y;
    logic       moved, blocked, at_goal, busy;

    typedef struct {
        int kind;
        int x;
        int y;
    } ev_t;

    ev_t  sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   px    = 0;
    int   py    = 0;
    bit   mon_en     = 1'b0;
    bit   resp_on    = 1'b1;
    int   resp_delay = 1;
    bit   late_kick  = 1'b0;
    logic req_prev   = 1'b0;
    logic [3:0] held_x, held_y;
    logic wall_map [0:15][0:15];

    maze_player_mover #(
        .COORD_W(4), .GRID_W(16), .GRID_H(16),
        .START_X(0), .START_Y(0), .GOAL_X(15), .GOAL_Y(15),
        .REPEAT_CYCLES(REP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .direction(direction), .restart(restart),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_valid(wall_valid), .wall_is_wall(wall_is_wall),
        .pos_x(pos_x), .pos_y(pos_y), .moved(moved), .blocked(blocked),
        .at_goal(at_goal), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int x, input int y);
        ev_t e;
        e.kind = kind;
        e.x    = x;
        e.y    = y;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input int kind, input int x, input int y);
        ev_t e;
        if (sb_q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
        end else begin
            e = sb_q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_x", x, e.x);
            chk("ev_y", y, e.y);
        end
    endtask

    // Output monitor: every lookup start, move and block must match the queue head.
    always @(negedge clock) begin
        if (mon_en) begin
            if (moved && blocked) chk("moved_blocked_same_cycle", 1, 0);
            if (wall_req && req_prev && (wall_x != held_x || wall_y != held_y))
                chk("wall_xy_stable", int'({wall_x, wall_y}), int'({held_x, held_y}));
            if (wall_req && !req_prev) sb_check(K_LOOK, int'(wall_x), int'(wall_y));
            if (moved)   sb_check(K_MOVE, int'(pos_x), int'(pos_y));
            if (blocked) sb_check(K_BLOCK, int'(pos_x), int'(pos_y));
            req_prev = wall_req;
            held_x   = wall_x;
            held_y   = wall_y;
        end
    end

    // Wall map responder with configurable latency, plus a one-shot stray answer.
    initial begin
        wall_valid   = 1'b0;
        wall_is_wall = 1'b0;
        forever begin
            @(negedge clock);
            if (late_kick) begin
                wall_valid   = 1'b1;
                wall_is_wall = 1'b0;
                @(negedge clock);
                wall_valid   = 1'b0;
            end else if (resp_on && wall_req) begin
                repeat (resp_delay - 1) @(negedge clock);
                wall_valid   = 1'b1;
                wall_is_wall = wall_map[wall_x][wall_y];
                @(negedge clock);
                wall_valid   = 1'b0;
                wall_is_wall = 1'b0;
            end
        end
    end

    task automatic do_step(input logic [3:0] d);
        direction = d;
        @(negedge clock);
        direction = 4'b0000;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic chk_pos(input string tag);
        chk({tag, "_x"}, int'(pos_x), px);
        chk({tag, "_y"}, int'(pos_y), py);
    endtask

    task automatic move_ok(input logic [3:0] d);
        int nx, ny;
        nx = px;
        ny = py;
        case (d)
            4'b0001: ny = py - 1;
            4'b0010: ny = py + 1;
            4'b0100: nx = px + 1;
            default: nx = px - 1;
        endcase
        push(K_LOOK, nx, ny);
        push(K_MOVE, nx, ny);
        do_step(d);
        drain(60);
        px = nx;
        py = ny;
    endtask

    task automatic expect_block(input logic [3:0] d);
        push(K_BLOCK, px, py);
        do_step(d);
        drain(60);
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                wall_map[x][y] = 1'b0;
        wall_map[2][4] = 1'b1;

        reset     = 1'b0;
        direction = 4'b0000;
        restart   = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_pos_x", int'(pos_x), 0);
        chk("rst_pos_y", int'(pos_y), 0);
        chk("rst_wall_req", int'(wall_req), 0);
        chk("rst_moved", int'(moved), 0);
        chk("rst_blocked", int'(blocked), 0);
        chk("rst_at_goal", int'(at_goal), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;

        // Single right move, lookup answered after 3 cycles.
        resp_delay = 3;
        push(K_LOOK, 1, 0);
        push(K_MOVE, 1, 0);
        direction = 4'b0100;
        @(negedge clock);
        direction = 4'b0000;
        chk("req_latency", int'(wall_req), 1);
        drain(60);
        px = 1;
        chk_pos("first_move");
        resp_delay = 1;

        // Left edge and top edge at the origin.
        move_ok(4'b1000);
        expect_block(4'b1000);
        expect_block(4'b0001);
        chk_pos("edge_origin");

        // Walk to (2,3), then bump into the wall at (2,4).
        move_ok(4'b0100);
        move_ok(4'b0100);
        move_ok(4'b0010);
        move_ok(4'b0010);
        move_ok(4'b0010);
        push(K_LOOK, 2, 4);
        push(K_BLOCK, 2, 3);
        do_step(4'b0010);
        drain(60);
        chk_pos("wall_block");

        // Held right key: first edge plus three repeat periods gives four moves.
        for (int i = 1; i <= 4; i++) begin
            push(K_LOOK, px + i, py);
            push(K_MOVE, px + i, py);
        end
        direction = 4'b0100;
        repeat (3 * REP + 1) @(negedge clock);
        direction = 4'b0110;
        repeat (10) @(negedge clock);
        direction = 4'b0000;
        drain(60);
        px = px + 4;
        chk_pos("auto_repeat");

        // Lookup never answered: request held for exactly TMO cycles, then blocked.
        resp_on = 1'b0;
        push(K_LOOK, px, py - 1);
        push(K_BLOCK, px, py);
        direction = 4'b0001;
        @(negedge clock);
        direction = 4'b0000;
        n = 0;
        while (wall_req && n < 400) begin
            n++;
            @(negedge clock);
        end
        chk("timeout_req_cycles", n, TMO);
        drain(60);
        chk_pos("timeout");

        // Restart mid-lookup; a stray answer afterwards must be ignored.
        push(K_LOOK, px, py + 1);
        do_step(4'b0010);
        repeat (3) @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        px = 0;
        py = 0;
        chk("restart_wall_req", int'(wall_req), 0);
        chk("restart_busy", int'(busy), 0);
        chk_pos("restart_mid");
        @(posedge clock);
        late_kick = 1'b1;
        @(posedge clock);
        late_kick = 1'b0;
        repeat (4) @(negedge clock);
        drain(60);
        chk_pos("late_valid_ignored");
        resp_on = 1'b1;

        // Walk to the goal; check the right edge on the way.
        for (int i = 0; i < 15; i++) move_ok(4'b0100);
        expect_block(4'b0100);
        for (int i = 0; i < 14; i++) move_ok(4'b0010);
        chk("before_goal", int'(at_goal), 0);
        move_ok(4'b0010);
        chk("at_goal_set", int'(at_goal), 1);
        do_step(4'b1000);
        drain(30);
        do_step(4'b0001);
        drain(30);
        chk_pos("goal_frozen");
        chk("at_goal_held", int'(at_goal), 1);

        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        px = 0;
        py = 0;
        drain(10);
        chk_pos("goal_restart");
        chk("goal_restart_flag", int'(at_goal), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
